// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: round-robin arbiter sharing one serial-opcode ALU among
// NUM_REQ requesters. Each grant drives a two-cycle opcode/data load, waits
// for alu_done (or times out and pulses the ALU reset), then returns the
// captured result to the owning requester. All outputs are registered.
// Optional: define ALU_ARB_CTRL_STATS_EN to add stat_ops / stat_timeouts.
module alu_arb_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [2*NUM_REQ-1:0]          req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_result,
    output logic                          resp_overflow,
    output logic                          resp_error,
    output logic                          alu_reset_n,
    output logic                          alu_opcode_valid,
    output logic                          alu_opcode,
    output logic [DATA_WIDTH-1:0]         alu_data,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_overflow,
    input  logic                          alu_done
`ifdef ALU_ARB_CTRL_STATS_EN
    ,
    output logic [15:0]                   stat_ops,
    output logic [7:0]                    stat_timeouts
`endif
);

    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_OP1, S_OP2, S_WAIT, S_RECOVER, S_RESP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [IDXW-1:0]       r_ptr;       // last winner; doubles as owner of the op in flight
    logic                  r_op_hi;     // opcode[0] and A are consumed at the IDLE edge,
    logic [DATA_WIDTH-1:0] r_b;         // so only opcode[1] and B need latching
    logic [CNTW-1:0]       r_cnt;

    logic [IDXW-1:0]       w_win_idx, w_cand;
    logic                  w_win_found;
    logic [1:0]            w_op_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_a_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_b_arr  [NUM_REQ];

    logic [NUM_REQ-1:0]    r_gnt, r_rv, w_gnt_nxt, w_rv_nxt;
    logic [DATA_WIDTH-1:0] r_res, r_data, w_res_nxt, w_data_nxt;
    logic                  r_ovf, r_err, r_rstn, r_ovalid, r_op;
    logic                  w_ovf_nxt, w_err_nxt, w_rstn_nxt, w_ovalid_nxt, w_op_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_op_arr[g] = req_opcode[2*g +: 2];
        assign w_a_arr[g]  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_b_arr[g]  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first set req bit starting at pointer+1, wrapping
    always_comb begin
        w_win_idx   = r_ptr;
        w_win_found = 1'b0;
        w_cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDXW'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_win_found && req[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; alu_done takes precedence over the timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_win_found) w_state_nxt = S_OP1;
            S_OP1:     w_state_nxt = S_OP2;
            S_OP2:     w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_done)                          w_state_nxt = S_RESP;
                else if (r_cnt == CNTW'(TIMEOUT - 1))  w_state_nxt = S_RECOVER;
            end
            S_RECOVER: w_state_nxt = S_RESP;
            S_RESP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Request commit at the IDLE edge and WAIT-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= IDXW'(NUM_REQ - 1);
            r_op_hi <= 1'b0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && w_win_found) begin
                r_ptr   <= w_win_idx;
                r_op_hi <= w_op_arr[w_win_idx][1];
                r_b     <= w_b_arr[w_win_idx];
            end
            if (r_state == S_OP2)
                r_cnt <= '0;
            else if (r_state == S_WAIT && !alu_done)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output decode from the next state so every output lands in a register
    always_comb begin
        w_gnt_nxt    = '0;
        w_rv_nxt     = '0;
        w_res_nxt    = r_res;
        w_ovf_nxt    = r_ovf;
        w_err_nxt    = 1'b0;
        w_rstn_nxt   = 1'b1;
        w_ovalid_nxt = 1'b0;
        w_op_nxt     = 1'b0;
        w_data_nxt   = '0;
        case (w_state_nxt)
            S_OP1: begin
                w_gnt_nxt[w_win_idx] = 1'b1;
                w_ovalid_nxt         = 1'b1;
                w_op_nxt             = w_op_arr[w_win_idx][0];
                w_data_nxt           = w_a_arr[w_win_idx];
            end
            S_OP2: begin
                w_ovalid_nxt = 1'b1;
                w_op_nxt     = r_op_hi;
                w_data_nxt   = r_b;
            end
            S_RECOVER: w_rstn_nxt = 1'b0;
            S_RESP: begin
                w_rv_nxt[r_ptr] = 1'b1;
                if (r_state == S_RECOVER) begin
                    w_res_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    w_err_nxt = 1'b1;
                end else begin
                    w_res_nxt = alu_result;
                    w_ovf_nxt = alu_overflow;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt    <= '0;
            r_rv     <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_rstn   <= 1'b0;
            r_ovalid <= 1'b0;
            r_op     <= 1'b0;
            r_data   <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_rv     <= w_rv_nxt;
            r_res    <= w_res_nxt;
            r_ovf    <= w_ovf_nxt;
            r_err    <= w_err_nxt;
            r_rstn   <= w_rstn_nxt;
            r_ovalid <= w_ovalid_nxt;
            r_op     <= w_op_nxt;
            r_data   <= w_data_nxt;
        end
    end

    assign gnt              = r_gnt;
    assign resp_valid       = r_rv;
    assign resp_result      = r_res;
    assign resp_overflow    = r_ovf;
    assign resp_error       = r_err;
    assign alu_reset_n      = r_rstn;
    assign alu_opcode_valid = r_ovalid;
    assign alu_opcode       = r_op;
    assign alu_data         = r_data;

`ifdef ALU_ARB_CTRL_STATS_EN
    logic [15:0] r_stat_ops;
    logic [7:0]  r_stat_timeouts;

    // Saturating counters of good responses and timeouts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_ops      <= '0;
            r_stat_timeouts <= '0;
        end else begin
            if (r_state == S_RESP && !r_err && r_stat_ops != '1)
                r_stat_ops <= r_stat_ops + 1'b1;
            if (r_state == S_RECOVER && r_stat_timeouts != '1)
                r_stat_timeouts <= r_stat_timeouts + 1'b1;
        end
    end

    assign stat_ops      = r_stat_ops;
    assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb_alu_arb_ctrl: directed, table-driven bench for alu_arb_ctrl with a
// behavioural serial-opcode ALU whose done latency is set per operation.
module tb_alu_arb_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic [3:0]  gnt, resp_valid;
    logic [7:0]  resp_result;
    logic        resp_overflow, resp_error, alu_reset_n, alu_opcode_valid, alu_opcode;
    logic [7:0]  alu_data, alu_result;
    logic        alu_overflow, alu_done;
`ifdef ALU_ARB_CTRL_STATS_EN
    logic [15:0] stat_ops;
    logic [7:0]  stat_timeouts;
`endif

    alu_arb_ctrl #(.DATA_WIDTH(8), .NUM_REQ(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .resp_valid(resp_valid),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_error(resp_error), .alu_reset_n(alu_reset_n),
        .alu_opcode_valid(alu_opcode_valid), .alu_opcode(alu_opcode),
        .alu_data(alu_data), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .alu_done(alu_done)
`ifdef ALU_ARB_CTRL_STATS_EN
        , .stat_ops(stat_ops), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned alu_dly  = 2;   // cycles after the OP2 cycle until done; 0 = never

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural ALU, evaluated on the falling edge
    initial begin
        int       cd;
        bit       phase;
        logic     op0, op1;
        logic [7:0] ma, mb, mres;
        logic     movf;
        alu_done = 1'b0; alu_result = 8'hC3; alu_overflow = 1'b1;
        cd = 0; phase = 1'b0; op0 = 1'b0; op1 = 1'b0; ma = '0; mb = '0; mres = '0; movf = 1'b0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0; alu_result = 8'hC3; alu_overflow = 1'b1;
            if (reset || !alu_reset_n) begin
                cd = 0; phase = 1'b0;
            end else begin
                if (cd != 0) begin
                    cd--;
                    if (cd == 0) begin
                        alu_done = 1'b1; alu_result = mres; alu_overflow = movf;
                    end
                end
                if (alu_opcode_valid) begin
                    if (!phase) begin
                        op0 = alu_opcode; ma = alu_data; phase = 1'b1;
                    end else begin
                        op1 = alu_opcode; mb = alu_data; phase = 1'b0;
                        case ({op1, op0})
                            2'b00: {movf, mres} = {1'b0, ma} + {1'b0, mb};
                            2'b01: begin mres = ma - mb; movf = (ma < mb); end
                            2'b10: begin mres = ma ^ mb; movf = 1'b0; end
                            default: begin mres = ~(ma ^ mb); movf = 1'b0; end
                        endcase
                        cd = int'(alu_dly);
                    end
                end
            end
        end
    end

    // Follows one operation from its grant through the cycle after its response
    task automatic wait_op(input string tag, input int unsigned eidx,
                           input logic [1:0] eop, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] eres, input logic eovf, input logic eerr,
                           input int unsigned elat, input int unsigned erlow, input bit drop);
        int unsigned t, lat, rlow, xg, xv;
        t = 0;
        while (gnt == 4'b0 && t < 40) begin @(negedge clk); t++; end
        if (gnt == 4'b0) begin
            chk({tag, " gnt_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " gnt"}, 32'(gnt), 32'(4'b1 << eidx));
        chk({tag, " op1_valid"}, 32'(alu_opcode_valid), 32'd1);
        chk({tag, " op1_opcode"}, 32'(alu_opcode), 32'(eop[0]));
        chk({tag, " op1_data"}, 32'(alu_data), 32'(ea));
        if (drop) req = 4'b0;
        @(negedge clk);
        chk({tag, " op2_gnt_low"}, 32'(gnt), 32'd0);
        chk({tag, " op2_valid"}, 32'(alu_opcode_valid), 32'd1);
        chk({tag, " op2_opcode"}, 32'(alu_opcode), 32'(eop[1]));
        chk({tag, " op2_data"}, 32'(alu_data), 32'(eb));
        lat = 1; rlow = 0; xg = 0; xv = 0;
        while (resp_valid == 4'b0 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!alu_reset_n) rlow++;
            if (gnt != 4'b0) xg++;
            if (alu_opcode_valid || alu_data != 8'h00) xv++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'(4'b1 << eidx));
        chk({tag, " resp_result"}, 32'(resp_result), 32'(eres));
        chk({tag, " resp_overflow"}, 32'(resp_overflow), 32'(eovf));
        chk({tag, " resp_error"}, 32'(resp_error), 32'(eerr));
        chk({tag, " alu_reset_low_cycles"}, rlow, erlow);
        chk({tag, " stray_gnt"}, xg, 0);
        chk({tag, " wait_bus_idle"}, xv, 0);
        @(negedge clk);
        chk({tag, " resp_pulse_end"}, 32'({resp_valid, resp_error}), 32'd0);
        chk({tag, " result_held"}, 32'(resp_result), 32'(eres));
    endtask

    typedef struct {
        int unsigned idx;
        logic [1:0]  op;
        logic [7:0]  a, b;
        int unsigned dly;
        logic [7:0]  res;
        logic        ovf, err;
        int unsigned lat, rlow;
    } vec_t;

    function automatic vec_t mk(int unsigned idx, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                int unsigned dly, logic [7:0] res, logic ovf, logic err,
                                int unsigned lat, int unsigned rlow);
        vec_t v;
        v.idx = idx; v.op = op; v.a = a; v.b = b; v.dly = dly;
        v.res = res; v.ovf = ovf; v.err = err; v.lat = lat; v.rlow = rlow;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int unsigned t, bad;
        vecs[0] = mk(0, 2'b00, 8'hF0, 8'h20, 2, 8'h10, 1'b1, 1'b0, 4, 0);   // add with carry
        vecs[1] = mk(2, 2'b10, 8'hAA, 8'h0F, 2, 8'hA5, 1'b0, 1'b0, 4, 0);   // xor
        vecs[2] = mk(1, 2'b01, 8'h10, 8'h20, 2, 8'hF0, 1'b1, 1'b0, 4, 0);   // sub with borrow
        vecs[3] = mk(3, 2'b11, 8'hAA, 8'h0F, 2, 8'h5A, 1'b0, 1'b0, 4, 0);   // xnor
        vecs[4] = mk(1, 2'b01, 8'h50, 8'h30, 3, 8'h20, 1'b0, 1'b0, 5, 0);   // slower ALU
        vecs[5] = mk(3, 2'b00, 8'h7F, 8'h01, 0, 8'h00, 1'b0, 1'b1, 11, 1);  // timeout
        vecs[6] = mk(0, 2'b10, 8'h33, 8'h0F, 8, 8'h3C, 1'b0, 1'b0, 10, 0);  // done in last WAIT cycle
        vecs[7] = mk(2, 2'b00, 8'h01, 8'h02, 2, 8'h03, 1'b0, 1'b0, 4, 0);   // recovery after timeout

        reset = 1'b1; req = '0; req_opcode = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({gnt, resp_valid, resp_result, resp_overflow, resp_error,
                                  alu_opcode_valid, alu_opcode}), 32'd0);
        chk("reset_alu_data", 32'(alu_data), 32'd0);
        chk("reset_alu_reset_n", 32'(alu_reset_n), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("alu_reset_n_release", 32'(alu_reset_n), 32'd1);
        @(negedge clk);

        // Single-requester table
        for (int unsigned k = 0; k < 8; k++) begin
            alu_dly = vecs[k].dly;
            req_opcode = '0; req_a = '0; req_b = '0;
            req_opcode[2*vecs[k].idx +: 2] = vecs[k].op;
            req_a[8*vecs[k].idx +: 8] = vecs[k].a;
            req_b[8*vecs[k].idx +: 8] = vecs[k].b;
            req = 4'b1 << vecs[k].idx;
            wait_op($sformatf("vec%0d", k), vecs[k].idx, vecs[k].op, vecs[k].a, vecs[k].b,
                    vecs[k].res, vecs[k].ovf, vecs[k].err, vecs[k].lat, vecs[k].rlow, 1'b1);
        end
`ifdef ALU_ARB_CTRL_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'd7);
        chk("stat_timeouts", 32'(stat_timeouts), 32'd1);
`endif

        // Round-robin fairness from a fresh pointer, all requesters held high
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        alu_dly = 2;
        req_opcode = '0; req_b = 32'h01010101; req_a = 32'h30201000;
        req = 4'b1111;
        for (int unsigned k = 0; k < 8; k++) begin
            wait_op($sformatf("rr%0d", k), k % 4, 2'b00, 8'(16 * (k % 4)), 8'h01,
                    8'(16 * (k % 4) + 1), 1'b0, 1'b0, 4, 0, 1'b0);
        end
        req = 4'b0;

        // Reset during WAIT aborts the operation without any pulse
        alu_dly = 0;
        req_opcode = '0; req_a = '0; req_b = '0;
        req_a[23:16] = 8'h44; req_b[23:16] = 8'h11;
        req = 4'b0100;
        t = 0;
        while (gnt == 4'b0 && t < 20) begin @(negedge clk); t++; end
        chk("abort_gnt", 32'(gnt), 32'h4);
        req = 4'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_outputs", 32'({gnt, resp_valid, resp_result, resp_overflow, resp_error,
                                  alu_opcode_valid, alu_opcode, alu_reset_n}), 32'd0);
        chk("abort_alu_data", 32'(alu_data), 32'd0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid != 4'b0 || gnt != 4'b0) bad++;
        end
        chk("abort_no_pulse", bad, 0);
        alu_dly = 2;
        req_opcode = 8'b00_00_01_00; req_a = 32'h00000900; req_b = 32'h00000400;
        req = 4'b0010;
        reset = 1'b0;
        // Released at a falling edge: the first rising edge commits, gnt shows in the next cycle
        t = 0; bad = 0;
        while (gnt == 4'b0 && t < 10) begin
            @(negedge clk);
            t++;
            if (resp_valid != 4'b0) bad++;
        end
        chk("post_reset_gnt_delay", t, 1);
        chk("post_reset_no_resp", bad, 0);
        wait_op("post_reset", 1, 2'b01, 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 4, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
